// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 shared word width, schedule FSM states and round constants
package sha256_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sched_state_t;

  // Round constants K[0..63]: first 32 bits of the fractional parts of the
  // cube roots of the first 64 primes.
  localparam logic [WORD_W-1:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

endpackage

// File: rtl/msg_sched_sigma.sv
// rtl/msg_sched_sigma.sv - combinational SHA-256 schedule sigma (s0 when UPPER=0, s1 when UPPER=1)
module msg_sched_sigma
  import sha256_pkg::*;
#(
  parameter bit UPPER = 1'b0
) (
  input  logic [WORD_W-1:0] x,
  output logic [WORD_W-1:0] y
);

  logic [WORD_W-1:0] s0;
  logic [WORD_W-1:0] s1;

  // s0 = ROTR7 ^ ROTR18 ^ SHR3 ; s1 = ROTR17 ^ ROTR19 ^ SHR10
  always_comb begin
    s0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    s1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    y  = UPPER ? s1 : s0;
  end

endmodule

// File: rtl/msg_schedule.sv
// rtl/msg_schedule.sv - SHA-256 message schedule, 16-word sliding window; optional MSG_SCHED_KCONST_EN drives k_word
module msg_schedule
  import sha256_pkg::*;
#(
  parameter int ROUNDS     = 64,
  parameter int BLOCK_BITS = 512
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  block_valid,
  input  logic [BLOCK_BITS-1:0] block,
  input  logic                  w_ready,
  output logic                  block_ready,
  output logic                  w_valid,
  output logic [WORD_W-1:0]     w_word,
  output logic [5:0]            w_index,
  output logic [WORD_W-1:0]     k_word,
  output logic                  schedule_complete
);

  localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

  sched_state_t      state;
  sched_state_t      state_next;
  logic [WORD_W-1:0] window [0:15];
  logic [5:0]        t;
  logic              bv_q;
  logic              start;
  logic              accept;
  logic              last;
  logic [WORD_W-1:0] sig0;
  logic [WORD_W-1:0] sig1;
  logic [WORD_W-1:0] next_word;

  // Upstream holds block_valid high indefinitely, so only a fresh rising edge starts a block.
  assign start  = (state == ST_IDLE) && enable && block_valid && !bv_q;
  assign accept = (state == ST_RUN) && enable && w_ready;
  assign last   = (t == LAST_T);

  msg_sched_sigma #(.UPPER(1'b0)) u_sig0 (
    .x (window[1]),
    .y (sig0)
  );

  msg_sched_sigma #(.UPPER(1'b1)) u_sig1 (
    .x (window[14]),
    .y (sig1)
  );

  // W[t+16] from the window: entry 14 is W[t+14], 9 is W[t+9], 1 is W[t+1], 0 is W[t].
  always_comb begin
    next_word = sig1 + window[9] + sig0 + window[0];
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; enable low aborts to IDLE from anywhere.
  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start) state_next = ST_RUN;
        ST_RUN:  if (accept && last) state_next = ST_DONE;
        ST_DONE: state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Edge flop, block capture, and window shift on each accepted beat.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bv_q <= 1'b0;
      t    <= '0;
      for (int i = 0; i < 16; i++) begin
        window[i] <= '0;
      end
    end else begin
      bv_q <= block_valid;
      if (start) begin
        t <= '0;
        for (int i = 0; i < 16; i++) begin
          window[i] <= block[BLOCK_BITS-1-WORD_W*i -: WORD_W];
        end
      end else if (accept) begin
        t <= t + 6'd1;
        for (int i = 0; i < 15; i++) begin
          window[i] <= window[i+1];
        end
        window[15] <= next_word;
      end
    end
  end

  assign block_ready       = (state == ST_IDLE);
  assign w_valid           = (state == ST_RUN);
  assign w_word            = w_valid ? window[0] : '0;
  assign w_index           = w_valid ? t : '0;
  assign schedule_complete = (state == ST_DONE);

`ifdef MSG_SCHED_KCONST_EN
  assign k_word = w_valid ? K[t] : '0;
`else
  assign k_word = '0;
`endif

endmodule

// File: tb/tb_msg_schedule.sv
// tb/tb_msg_schedule.sv - self-checking bench for msg_schedule against a whole-block schedule model
module tb_msg_schedule;

  logic         clock;
  logic         reset;
  logic         enable;
  logic         block_valid;
  logic [511:0] block;
  logic         w_ready;
  logic         block_ready;
  logic         w_valid;
  logic [31:0]  w_word;
  logic [5:0]   w_index;
  logic [31:0]  k_word;
  logic         schedule_complete;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] wexp [64];
  logic [31:0] got  [64];

  msg_schedule dut (
    .clock             (clock),
    .reset             (reset),
    .enable            (enable),
    .block_valid       (block_valid),
    .block             (block),
    .w_ready           (w_ready),
    .block_ready       (block_ready),
    .w_valid           (w_valid),
    .w_word            (w_word),
    .w_index           (w_index),
    .k_word            (k_word),
    .schedule_complete (schedule_complete)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Full 64-word expansion straight from the SHA-256 recurrence.
  task automatic build_model(input logic [511:0] blk);
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 16; i++) wexp[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      a = rotr(wexp[i-15], 7) ^ rotr(wexp[i-15], 18) ^ (wexp[i-15] >> 3);
      b = rotr(wexp[i-2], 17) ^ rotr(wexp[i-2], 19) ^ (wexp[i-2] >> 10);
      wexp[i] = b + wexp[i-7] + a + wexp[i-16];
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Present a block with a fresh rising edge of block_valid; expect w_valid one cycle later.
  task automatic start_block(input logic [511:0] blk);
    block_valid = 1'b0;
    tick();
    block = blk;
    build_model(blk);
    chk("ready_before_start", block_ready, 1);
    block_valid = 1'b1;
    tick();
    chk("latency_w_valid", w_valid, 1);
  endtask

  // Consume beats 0..upto-1; mode 0 always ready, 1 alternate 1-0, 2 random.
  task automatic stream(input int upto, input int mode);
    int          idx;
    int          budget;
    bit          stalled;
    logic [31:0] held;
    logic [5:0]  held_idx;
    idx = 0; budget = 0; stalled = 0; held = '0; held_idx = '0;
    while (idx < upto && budget < 1000) begin
      chk("w_valid", w_valid, 1);
      chk("complete_low", schedule_complete, 0);
      if (stalled) begin
        chk("stall_word", w_word, held);
        chk("stall_index", w_index, held_idx);
      end
      chk($sformatf("w_word[%0d]", idx), w_word, wexp[idx]);
      chk("w_index", w_index, idx);
`ifdef MSG_SCHED_KCONST_EN
      if (idx == 0) chk("k_t0", k_word, 32'h428A2F98);
      if (idx == 63) chk("k_t63", k_word, 32'hC67178F2);
`else
      chk("k_zero", k_word, 0);
`endif
      case (mode)
        0:       w_ready = 1'b1;
        1:       w_ready = (budget % 2 == 0);
        default: w_ready = 1'($urandom_range(0, 1));
      endcase
      if (w_ready) begin
        got[idx] = w_word;
        idx++;
      end
      stalled  = !w_ready;
      held     = w_word;
      held_idx = w_index;
      budget++;
      tick();
    end
    chk("beat_count", idx, upto);
  endtask

  task automatic finish_block();
    w_ready = 1'b0;
    chk("done_w_valid", w_valid, 0);
    chk("done_pulse", schedule_complete, 1);
    tick();
    chk("pulse_one_cycle", schedule_complete, 0);
    chk("back_idle", block_ready, 1);
  endtask

  logic [511:0] abc;

  initial begin
    reset       = 1'b1;
    enable      = 1'b1;
    block_valid = 1'b0;
    block       = '0;
    w_ready     = 1'b0;
    abc         = {32'h61626380, {14{32'h0}}, 32'h00000018};

    // Reset state
    #1;
    chk("rst_block_ready", block_ready, 1);
    chk("rst_w_valid", w_valid, 0);
    chk("rst_w_word", w_word, 0);
    chk("rst_w_index", w_index, 0);
    chk("rst_k_word", k_word, 0);
    chk("rst_complete", schedule_complete, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_idle", block_ready, 1);

    // 1: "abc" block, always ready
    start_block(abc);
    stream(64, 0);
    chk("abc_W0", got[0], 32'h61626380);
    chk("abc_W15", got[15], 32'h00000018);
    chk("abc_W16", got[16], 32'h61626380);
    chk("abc_W17", got[17], 32'h000F0000);
    finish_block();

    // 3: block_valid still high after DONE must not restart
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("held_no_restart", w_valid, 0);
      chk("held_ready", block_ready, 1);
    end

    // 2+3: new edge reruns the same block with w_ready toggling
    start_block(abc);
    stream(64, 1);
    finish_block();

    // random block, random backpressure
    start_block(rand_block());
    stream(64, 2);
    finish_block();

    // 4: enable dropped at t = 20
    start_block(rand_block());
    stream(20, 0);
    chk("abort_t20", w_index, 20);
    enable = 1'b0;
    tick();
    chk("abort_w_valid", w_valid, 0);
    chk("abort_ready", block_ready, 1);
    chk("abort_no_pulse", schedule_complete, 0);
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_stays_idle", w_valid, 0);
      chk("abort_no_pulse_late", schedule_complete, 0);
    end

    // 5: asynchronous reset at t = 40
    start_block(rand_block());
    stream(40, 2);
    w_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_w_valid", w_valid, 0);
    chk("arst_w_word", w_word, 0);
    chk("arst_w_index", w_index, 0);
    chk("arst_block_ready", block_ready, 1);
    chk("arst_complete", schedule_complete, 0);
    chk("arst_k_word", k_word, 0);
    block_valid = 1'b0;
    @(posedge clock);
    #3;
    reset = 1'b0;
    tick();
    chk("arst_idle", w_valid, 0);
    start_block(rand_block());
    stream(64, 0);
    finish_block();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
